// File: rtl/instruction_emitter.sv
// Packs field-level instructions into 64-bit words and writes them to
// instruction memory at consecutive addresses through a small FIFO.
module instruction_emitter #(
   parameter int ADDR_W     = 16,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  length,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_opcode,
   input  logic [3:0]        in_reg_op,
   input  logic [5:0]        in_op1,
   input  logic [5:0]        in_op2,
   input  logic [5:0]        in_dest,
   input  logic [5:0]        in_predicate,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              addr_wrap
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] accepted;
   logic [CNT_W-1:0] written;

   logic [63:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        start_ok;
   logic [63:0] word;

   assign word = {in_opcode, in_reg_op, in_op1, in_op2, in_dest,
                  28'b0, in_predicate};

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);

   // in_ready depends only on registered state, never on mem_ready
   assign in_ready = (state == LOAD) && !fifo_full && (accepted < len_q);
   assign push     = in_valid && in_ready;
   assign mem_we   = !fifo_empty;
   assign pop      = mem_we && mem_ready;
   assign start_ok = (state == IDLE) && start;

   assign mem_wdata = mem_we ? fifo_mem[rd_ptr] : '0;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = (length == '0) ? DONE : LOAD;
         end
         LOAD: begin
            if (accepted == len_q) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (written == len_q) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         accepted  <= '0;
         written   <= '0;
         len_q     <= '0;
         mem_addr  <= '0;
         addr_wrap <= 1'b0;
      end else if (start_ok) begin
         len_q     <= length;
         accepted  <= '0;
         written   <= '0;
         mem_addr  <= base_addr;
         addr_wrap <= 1'b0;
      end else begin
         if (push) begin
            accepted <= accepted + 1'b1;
            wr_ptr   <= wr_ptr + 1'b1;
         end
         if (pop) begin
            written  <= written + 1'b1;
            rd_ptr   <= rd_ptr + 1'b1;
            mem_addr <= mem_addr + 1'b1;
            if (&mem_addr) addr_wrap <= 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_emitter.sv
// Scoreboard bench for instruction_emitter: stimulus pushes expected
// writes, a negedge monitor pops and compares every completed write.
module tb_instruction_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] length;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_opcode;
   logic [3:0]  in_reg_op;
   logic [5:0]  in_op1;
   logic [5:0]  in_op2;
   logic [5:0]  in_dest;
   logic [5:0]  in_predicate;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ready;
   logic        busy;
   logic        done;
   logic        addr_wrap;

   instruction_emitter #(
      .ADDR_W(16), .CNT_W(16), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .base_addr(base_addr), .length(length),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_reg_op(in_reg_op),
      .in_op1(in_op1), .in_op2(in_op2), .in_dest(in_dest),
      .in_predicate(in_predicate),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .busy(busy), .done(done),
      .addr_wrap(addr_wrap)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;

   logic [79:0] sb[$];
   logic [35:0] vf [6];
   logic [63:0] vw [6];
   logic [15:0] exp_addr;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: compare every completed write and hold-stability on stall
   logic        stalled = 1'b0;
   logic [15:0] st_addr;
   logic [63:0] st_data;
   logic [79:0] e;
   always @(negedge clk) begin
      if (reset) begin
         stalled = 1'b0;
      end else begin
         if (stalled && mem_we) begin
            chk("hold_addr", {48'b0, mem_addr}, {48'b0, st_addr});
            chk("hold_data", mem_wdata, st_data);
         end
         if (mem_we && mem_ready) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_write", {48'b0, mem_addr}, 64'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", {48'b0, mem_addr}, {48'b0, e[79:64]});
               chk("wr_data", mem_wdata, e[63:0]);
            end
         end
         stalled = mem_we && !mem_ready;
         st_addr = mem_addr;
         st_data = mem_wdata;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [15:0] b, input logic [15:0] l);
      start     = 1'b1;
      base_addr = b;
      length    = l;
      exp_addr  = b;
      cyc();
      start     = 1'b0;
      base_addr = 16'h5A5A;
      length    = 16'h0007;
   endtask

   task automatic send(input int k);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      {in_opcode, in_reg_op, in_op1, in_op2, in_dest, in_predicate} = vf[k];
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         cyc();
      end
      n_cmp++;
      if (ok) begin
         sb.push_back({exp_addr, vw[k]});
         exp_addr = exp_addr + 16'd1;
      end else begin
         n_err++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 (vec %0d)", k);
      end
      in_valid = 1'b0;
      {in_opcode, in_reg_op, in_op1, in_op2, in_dest, in_predicate} = '1;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", {63'b0, seen}, 64'd1);
      chk("sb_empty_at_done", sb.size(), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", {63'b0, done}, 64'd0);
      chk("busy_after_done", {63'b0, busy}, 64'd0);
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vf[0] = {8'hA5, 4'h3, 6'h01, 6'h02, 6'h3F, 6'h15};
      vw[0] = 64'hA53042FC_00000015;
      vf[1] = {8'h00, 4'h0, 6'h00, 6'h00, 6'h00, 6'h00};
      vw[1] = 64'h00000000_00000000;
      vf[2] = {8'hFF, 4'hF, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
      vw[2] = 64'hFFFFFFFC_0000003F;
      vf[3] = {8'h12, 4'h4, 6'h20, 6'h10, 6'h08, 6'h2A};
      vw[3] = 64'h12481020_0000002A;
      vf[4] = {8'h01, 4'h1, 6'h01, 6'h01, 6'h01, 6'h01};
      vw[4] = 64'h01104104_00000001;
      vf[5] = {8'hC3, 4'hA, 6'h15, 6'h2A, 6'h0C, 6'h3F};
      vw[5] = 64'hC3A56A30_0000003F;

      reset     = 1'b1;
      start     = 1'b1;
      base_addr = 16'h1234;
      length    = 16'd3;
      in_valid  = 1'b1;
      mem_ready = 1'b1;
      {in_opcode, in_reg_op, in_op1, in_op2, in_dest, in_predicate} = '1;
      exp_addr  = '0;
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
      chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
      chk("rst_mem_addr", {48'b0, mem_addr}, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_addr_wrap", {63'b0, addr_wrap}, 64'd0);
      cyc();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      cyc();

      // single instruction
      start_load(16'h0010, 16'd1);
      send(0);
      wait_done();

      // zero-length load
      start_load(16'h0020, 16'd0);
      wait_done();

      // back-pressure fills the FIFO
      mem_ready = 1'b0;
      start_load(16'h0040, 16'd6);
      for (int k = 0; k < 4; k++) send(k);
      in_valid = 1'b1;
      {in_opcode, in_reg_op, in_op1, in_op2, in_dest, in_predicate} = vf[4];
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("full_in_ready", {63'b0, in_ready}, 64'd0);
         chk("full_mem_we", {63'b0, mem_we}, 64'd1);
         chk("full_mem_addr", {48'b0, mem_addr}, 64'h0040);
      end
      cyc();
      mem_ready = 1'b1;
      send(4);
      send(5);
      wait_done();

      // address wrap
      start_load(16'hFFFE, 16'd3);
      send(1);
      send(2);
      send(3);
      wait_done();
      chk("wrap_set", {63'b0, addr_wrap}, 64'd1);
      start_load(16'h0100, 16'd1);
      @(negedge clk);
      chk("wrap_cleared", {63'b0, addr_wrap}, 64'd0);
      cyc();
      send(5);
      wait_done();

      // reset mid-load after two writes
      mem_ready = 1'b0;
      start_load(16'h0200, 16'd5);
      send(0);
      send(1);
      send(2);
      mem_ready = 1'b1;
      cyc();
      cyc();
      mem_ready = 1'b0;
      reset     = 1'b1;
      chk("t5_two_written", sb.size(), 64'd1);
      cyc();
      @(negedge clk);
      chk("t5_mem_we", {63'b0, mem_we}, 64'd0);
      chk("t5_busy", {63'b0, busy}, 64'd0);
      chk("t5_in_ready", {63'b0, in_ready}, 64'd0);
      sb.delete();
      cyc();
      reset     = 1'b0;
      mem_ready = 1'b1;
      cyc();
      start_load(16'h0300, 16'd1);
      send(4);
      wait_done();

      // start during LOAD is ignored
      start_load(16'h0400, 16'd3);
      send(0);
      start     = 1'b1;
      base_addr = 16'h0500;
      length    = 16'd1;
      cyc();
      start     = 1'b0;
      send(3);
      send(5);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
